// File: rtl/spi_cfg_ctrl_s_if.sv
// spi_cfg_ctrl_s_if -- SPI pin bundle for the configuration controller.
//   sclk   : serial clock (master -> slave), idles low (mode 0)
//   csb    : chip select, active-low (master -> slave)
//   sdi    : serial data into the slave
//   sdo    : serial data out of the slave
//   sdo_oe : high while the slave drives sdo
interface spi_cfg_ctrl_s_if;
    logic sclk;
    logic csb;
    logic sdi;
    logic sdo;
    logic sdo_oe;

    modport master (output sclk, csb, sdi, input  sdo, sdo_oe);
    modport slave  (input  sclk, csb, sdi, output sdo, sdo_oe);
endinterface

// File: rtl/spi_cfg_ctrl_s.sv
// spi_cfg_ctrl_s -- SPI mode-0 slave that fills an 8K x 8 shadow register
// array and commits it to the active register file via transfer_reg.
// Ports:
//   clk          : system clock, at least 8x sclk
//   reset        : synchronous, active-low
//   spi          : SPI pins (slave modport of spi_cfg_ctrl_s_if)
//   shadow       : shadow register array, one byte per 13-bit address
//   transfer_reg : one-clk commit pulse
//   busy         : high while the controller is not idle
// Frame: 16-bit instruction {R/W, W1:W0, addr[12:0]} then data bytes,
// MSB first, address decrementing after every byte.
module spi_cfg_ctrl_s #(
    parameter logic [7:0]  CHIP_ID   = 8'h82,
    parameter logic [12:0] XFER_ADDR = 13'h0FF
) (
    input  logic            clk,
    input  logic            reset,
    spi_cfg_ctrl_s_if.slave spi,
    output logic [7:0]      shadow [0:8191],
    output logic            transfer_reg,
    output logic            busy
);
    localparam logic [12:0] ID_ADDR = 13'h001;

    typedef enum logic [2:0] {IDLE, INSTR, WR_DATA, RD_DATA, HOLD} state_t;

    state_t      r_state;
    logic [1:0]  r_sclk_sync, r_csb_sync, r_sdi_sync;
    logic        r_sclk_d, r_csb_d;
    logic [3:0]  r_bit_cnt;
    logic [14:0] r_sr;
    logic [12:0] r_addr;
    logic [1:0]  r_bytes_left;      // bytes remaining after the current one
    logic        r_stream;
    logic [7:0]  r_rd_sr;
    logic        r_wr_pend;
    logic [12:0] r_wr_addr;
    logic [7:0]  r_wr_data;
    logic        r_xfer_pend;
    logic        r_sdo, r_sdo_oe, r_busy, r_transfer;

    logic        w_sclk_rise, w_sclk_fall, w_csb_rise, w_csb_fall, w_sdi;
    logic [15:0] w_sr_next;
    logic [12:0] w_next_addr;
    logic        w_last_byte;

    assign w_sclk_rise = r_sclk_sync[1] & ~r_sclk_d;
    assign w_sclk_fall = ~r_sclk_sync[1] & r_sclk_d;
    assign w_csb_rise  = r_csb_sync[1] & ~r_csb_d;
    assign w_csb_fall  = ~r_csb_sync[1] & r_csb_d;
    assign w_sdi       = r_sdi_sync[1];
    assign w_sr_next   = {r_sr, w_sdi};
    assign w_next_addr = r_addr - 13'd1;     // 13-bit wrap 0000 -> 1FFF
    assign w_last_byte = !r_stream && (r_bytes_left == 2'd0);

    assign spi.sdo      = r_sdo;
    assign spi.sdo_oe   = r_sdo_oe;
    assign transfer_reg = r_transfer;
    assign busy         = r_busy;

    // The chip-ID location reads as a constant, never from the array.
    function automatic logic [7:0] rd_byte(input logic [12:0] a);
        return (a == ID_ADDR) ? CHIP_ID : shadow[a];
    endfunction

    // NOTE: all state here is sequential, so every assignment is non-blocking;
    // later assignments in the block override earlier defaults.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state      <= IDLE;
            // Synchronizers clear to 0 so a csb held low across reset release
            // never looks like a falling edge: SPI stays ignored until a real
            // csb fall.
            r_sclk_sync  <= '0;
            r_csb_sync   <= '0;
            r_sdi_sync   <= '0;
            r_sclk_d     <= 1'b0;
            r_csb_d      <= 1'b0;
            r_bit_cnt    <= '0;
            r_sr         <= '0;
            r_addr       <= '0;
            r_bytes_left <= '0;
            r_stream     <= 1'b0;
            r_rd_sr      <= '0;
            r_wr_pend    <= 1'b0;
            r_wr_addr    <= '0;
            r_wr_data    <= '0;
            r_xfer_pend  <= 1'b0;
            r_sdo        <= 1'b0;
            r_sdo_oe     <= 1'b0;
            r_busy       <= 1'b0;
            r_transfer   <= 1'b0;
            // NOTE: the shadow array is architecturally cleared by reset, so
            // it is built from flops rather than a RAM macro.
            for (int i = 0; i < 8192; i++) begin
                shadow[i[12:0]] <= '0;
            end
        end else begin
            r_sclk_sync <= {r_sclk_sync[0], spi.sclk};
            r_csb_sync  <= {r_csb_sync[0], spi.csb};
            r_sdi_sync  <= {r_sdi_sync[0], spi.sdi};
            r_sclk_d    <= r_sclk_sync[1];
            r_csb_d     <= r_csb_sync[1];

            // Commit path runs outside the FSM so a csb rise landing on the
            // commit clk cannot cancel the write or its transfer pulse.
            r_wr_pend   <= 1'b0;
            r_xfer_pend <= 1'b0;
            r_transfer  <= r_xfer_pend;
            if (r_wr_pend && (r_wr_addr != ID_ADDR)) begin
                if (r_wr_addr == XFER_ADDR) begin
                    shadow[r_wr_addr] <= {r_wr_data[7:1], 1'b0};
                    r_xfer_pend       <= r_wr_data[0];
                end else begin
                    shadow[r_wr_addr] <= r_wr_data;
                end
            end

            if (w_csb_rise) begin
                r_state   <= IDLE;
                r_busy    <= 1'b0;
                r_sdo     <= 1'b0;
                r_sdo_oe  <= 1'b0;
                r_bit_cnt <= '0;
            end else begin
                case (r_state)
                    IDLE: begin
                        if (w_csb_fall) begin
                            r_state   <= INSTR;
                            r_busy    <= 1'b1;
                            r_bit_cnt <= '0;
                        end
                    end
                    INSTR: begin
                        if (w_sclk_rise) begin
                            r_sr      <= w_sr_next[14:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd15) begin
                                r_bit_cnt    <= '0;
                                r_addr       <= w_sr_next[12:0];
                                r_bytes_left <= w_sr_next[14:13];
                                r_stream     <= &w_sr_next[14:13];
                                if (w_sr_next[15]) begin
                                    r_state  <= RD_DATA;
                                    r_sdo_oe <= 1'b1;
                                    r_rd_sr  <= rd_byte(w_sr_next[12:0]);
                                end else begin
                                    r_state <= WR_DATA;
                                end
                            end
                        end
                    end
                    WR_DATA: begin
                        if (w_sclk_rise) begin
                            r_sr      <= w_sr_next[14:0];
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt    <= '0;
                                r_wr_pend    <= 1'b1;
                                r_wr_addr    <= r_addr;
                                r_wr_data    <= w_sr_next[7:0];
                                r_addr       <= w_next_addr;
                                r_bytes_left <= r_bytes_left - 2'd1;
                                if (w_last_byte) begin
                                    r_state <= HOLD;
                                end
                            end
                        end
                    end
                    RD_DATA: begin
                        if (w_sclk_fall) begin
                            r_sdo   <= r_rd_sr[7];
                            r_rd_sr <= {r_rd_sr[6:0], 1'b0};
                        end
                        // Bytes are counted on the rise where the master
                        // samples the last bit; the next byte is preloaded
                        // well before the following fall.
                        if (w_sclk_rise) begin
                            r_bit_cnt <= r_bit_cnt + 4'd1;
                            if (r_bit_cnt == 4'd7) begin
                                r_bit_cnt    <= '0;
                                r_addr       <= w_next_addr;
                                r_rd_sr      <= rd_byte(w_next_addr);
                                r_bytes_left <= r_bytes_left - 2'd1;
                                if (w_last_byte) begin
                                    r_state  <= HOLD;
                                    r_sdo    <= 1'b0;
                                    r_sdo_oe <= 1'b0;
                                end
                            end
                        end
                    end
                    HOLD: begin
                        // Wait for csb to rise; sclk is ignored.
                    end
                    default: begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_spi_cfg_ctrl_s.sv
// tb_spi_cfg_ctrl_s -- directed plus randomized bench for spi_cfg_ctrl_s.
// A transaction-level model (byte array, address arithmetic) predicts the
// shadow contents, read data and number of transfer pulses.
module tb_spi_cfg_ctrl_s;
    localparam logic [7:0]  CHIP_ID   = 8'h82;
    localparam logic [12:0] XFER_ADDR = 13'h0FF;
    localparam int          HALF      = 80;     // sclk half period (16 clk per sclk)

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] sh [0:8191];
    logic       transfer_reg;
    logic       busy;

    spi_cfg_ctrl_s_if spi ();

    spi_cfg_ctrl_s dut (
        .clk          (clk),
        .reset        (reset),
        .spi          (spi),
        .shadow       (sh),
        .transfer_reg (transfer_reg),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] m_sh [0:8191];
    logic [7:0] tx_q [$];
    logic [7:0] rx_q [$];
    logic [7:0] oe_q [$];
    logic [7:0] exp_rx [$];
    logic [7:0] exp_oe [$];

    // transfer_reg pulse monitor
    int xfer_cnt = 0;
    int run_len  = 0;
    int max_run  = 0;
    always @(negedge clk) begin
        if (transfer_reg === 1'b1) begin
            run_len = run_len + 1;
            if (run_len == 1) xfer_cnt = xfer_cnt + 1;
            if (run_len > max_run) max_run = run_len;
        end else begin
            run_len = 0;
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic sweep(input string tag);
        int         bad = 0;
        int         first = -1;
        logic [7:0] fo = '0;
        logic [7:0] fe = '0;
        for (int a = 0; a < 8192; a++) begin
            logic [12:0] idx;
            idx = a[12:0];
            if (sh[idx] !== m_sh[idx]) begin
                if (first < 0) begin
                    first = a;
                    fo    = sh[idx];
                    fe    = m_sh[idx];
                end
                bad++;
            end
        end
        n_vec++;
        assert (bad == 0) else begin
            n_err++;
            $error("FAIL %s: %0d bytes differ, first at %0h observed %0h expected %0h",
                   tag, bad, first, fo, fe);
        end
    endtask

    task automatic model_clear();
        for (int a = 0; a < 8192; a++) begin
            logic [12:0] idx;
            idx = a[12:0];
            m_sh[idx] = 8'h00;
        end
    endtask

    // Transaction-level prediction: byte k goes to (start - k) mod 8192.
    task automatic model_xact(input logic [15:0] instr, input int nbytes, output int exp_pulses);
        logic [12:0] a;
        logic [7:0]  d;
        int          limit;
        a          = instr[12:0];
        limit      = (instr[14:13] == 2'b11) ? nbytes : int'(instr[14:13]) + 1;
        exp_pulses = 0;
        exp_rx.delete();
        exp_oe.delete();
        for (int k = 0; k < nbytes; k++) begin
            if (k < limit) begin
                if (instr[15]) begin
                    exp_rx.push_back((a == 13'h001) ? CHIP_ID : m_sh[a]);
                    exp_oe.push_back(8'hFF);
                end else begin
                    d = tx_q[k];
                    exp_rx.push_back(8'h00);
                    exp_oe.push_back(8'h00);
                    if (a == 13'h001) begin
                        // ignored
                    end else if (a == XFER_ADDR) begin
                        m_sh[a] = d & 8'hFE;
                        if (d[0]) exp_pulses++;
                    end else begin
                        m_sh[a] = d;
                    end
                end
                a = a - 13'd1;
            end else begin
                exp_rx.push_back(8'h00);
                exp_oe.push_back(8'h00);
            end
        end
    endtask

    // One mode-0 bit: sdi set while sclk low, sdo sampled just before the rise.
    // With quick set, csb rises one clk after this rise.
    task automatic spi_bit(input logic b, input logic quick, output logic rb, output logic roe);
        spi.sdi = b;
        #(HALF);
        rb  = spi.sdo;
        roe = spi.sdo_oe;
        spi.sclk = 1'b1;
        if (quick) begin
            #10;
            spi.csb = 1'b1;
            #(HALF - 10);
        end else begin
            #(HALF);
        end
        spi.sclk = 1'b0;
    endtask

    task automatic spi_xact(input logic [15:0] instr, input int nbytes, input int extra,
                            input logic quick);
        logic       rb, roe;
        logic [7:0] d, r, o;
        rx_q.delete();
        oe_q.delete();
        spi.csb = 1'b0;
        #(2 * HALF);
        for (int i = 15; i >= 0; i--) spi_bit(instr[i], 1'b0, rb, roe);
        check("busy_in_xact", busy, 1);
        for (int k = 0; k < nbytes; k++) begin
            d = (k < tx_q.size()) ? tx_q[k] : 8'h00;
            for (int i = 7; i >= 0; i--) begin
                spi_bit(d[i], quick && (k == nbytes - 1) && (i == 0), rb, roe);
                r[i] = rb;
                o[i] = roe;
            end
            rx_q.push_back(r);
            oe_q.push_back(o);
        end
        for (int i = 0; i < extra; i++) spi_bit(1'b1, 1'b0, rb, roe);
        #(HALF);
        spi.csb = 1'b1;
        #(2 * HALF);
    endtask

    task automatic run(input string tag, input logic [15:0] instr, input int nbytes,
                       input int extra, input logic quick);
        int exp_p;
        int p0;
        p0 = xfer_cnt;
        while (tx_q.size() < nbytes) tx_q.push_back(8'h00);
        model_xact(instr, nbytes, exp_p);
        spi_xact(instr, nbytes, extra, quick);
        for (int k = 0; k < nbytes; k++) begin
            check($sformatf("%s_rx%0d", tag, k), rx_q[k], exp_rx[k]);
            check($sformatf("%s_oe%0d", tag, k), oe_q[k], exp_oe[k]);
        end
        check({tag, "_xfer_pulses"}, xfer_cnt - p0, exp_p);
        check({tag, "_busy_idle"}, busy, 0);
        check({tag, "_sdo_oe_idle"}, spi.sdo_oe, 0);
        check({tag, "_sdo_idle"}, spi.sdo, 0);
        sweep({tag, "_shadow"});
    endtask

    initial begin
        logic        rb, roe;
        logic [12:0] a;
        logic [15:0] instr;
        int          nb;

        reset    = 1'b0;
        spi.csb  = 1'b1;
        spi.sclk = 1'b0;
        spi.sdi  = 1'b0;
        model_clear();
        #100;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_sdo", spi.sdo, 0);
        check("rst_sdo_oe", spi.sdo_oe, 0);
        check("rst_transfer", transfer_reg, 0);
        sweep("rst_shadow");
        #20;
        reset = 1'b1;
        #200;

        // single-byte write
        tx_q = '{8'h05};
        run("wr_00B", 16'h000B, 1, 0, 1'b0);

        // three-byte write, fourth byte lands in HOLD
        tx_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run("wr3_01A", 16'h401A, 4, 0, 1'b0);

        // transfer register with bit0 set
        tx_q = '{8'h01};
        run("xfer_set", 16'h00FF, 1, 0, 1'b0);
        check("xfer_width", max_run, 1);
        check("xfer_shadow", sh[13'h0FF], 8'h00);

        // transfer register with bit0 clear
        tx_q = '{8'hA4};
        run("xfer_clr", 16'h00FF, 1, 0, 1'b0);

        // csb rises on the commit clk of an XFER write
        tx_q = '{8'h37};
        run("xfer_csb_race", 16'h00FF, 1, 0, 1'b1);

        // chip ID is read-only
        tx_q = '{8'h55};
        run("wr_id", 16'h0001, 1, 0, 1'b0);
        run("rd_id", 16'h8001, 2, 0, 1'b0);

        // two-byte read of written data
        run("rd_00B", 16'hA00B, 2, 0, 1'b0);

        // stream write across the address wrap
        tx_q = '{8'h11, 8'h22};
        run("stream_wrap", 16'h6000, 2, 0, 1'b0);
        run("stream_rd", 16'hE001, 3, 0, 1'b0);

        // randomized transactions around the interesting addresses
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 5))
                0:       a = 13'h0000;
                1:       a = 13'h0001;
                2:       a = XFER_ADDR;
                3:       a = XFER_ADDR + 13'd1;
                default: a = 13'($urandom);
            endcase
            instr = {1'($urandom), 2'($urandom), a};
            nb    = $urandom_range(1, 4);
            tx_q.delete();
            for (int k = 0; k < nb; k++) tx_q.push_back(8'($urandom));
            run($sformatf("rand%0d", t), instr, nb, 0, 1'b0);
        end

        // csb high after 5 data bits: partial byte discarded
        tx_q.delete();
        run("partial_csb", 16'h0030, 0, 5, 1'b0);

        // reset in the middle of a data byte
        spi.csb = 1'b0;
        #(2 * HALF);
        instr = 16'h0005;
        for (int i = 15; i >= 0; i--) spi_bit(instr[i], 1'b0, rb, roe);
        for (int i = 0; i < 3; i++) spi_bit(1'b1, 1'b0, rb, roe);
        reset = 1'b0;
        #50;
        @(negedge clk);
        model_clear();
        check("mid_rst_busy", busy, 0);
        check("mid_rst_sdo_oe", spi.sdo_oe, 0);
        check("mid_rst_transfer", transfer_reg, 0);
        reset = 1'b1;
        #20;
        // csb still low: these bits must be ignored
        for (int i = 0; i < 24; i++) spi_bit(1'b1, 1'b0, rb, roe);
        check("post_rst_busy", busy, 0);
        check("post_rst_sdo_oe", spi.sdo_oe, 0);
        spi.csb = 1'b1;
        #(2 * HALF);
        sweep("post_rst_shadow");

        // normal operation resumes
        tx_q = '{8'h3C};
        run("recover", 16'h0007, 1, 0, 1'b0);
        check("xfer_width_final", max_run, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
